// File: rtl/tipi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tipi_pkg: command codes, FSM encoding and frame constants for the TIPI SPI bus
// rev 1.0
// ---------------------------------------------------------------------------
package tipi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CMD_BITS   = 8;

    localparam logic [7:0] CMD_RD_TD = 8'h00;
    localparam logic [7:0] CMD_RD_TC = 8'h01;
    localparam logic [7:0] CMD_WR_RD = 8'h02;
    localparam logic [7:0] CMD_WR_RC = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tipi_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tipi_sync: STAGES-deep single-bit synchronizer, resets low
// rev 1.0
// ---------------------------------------------------------------------------
module tipi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/tipi_spi_pi_bus.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tipi_spi_pi_bus: SPI mode-0 slave exchanging TD/TC/RD/RC bytes with the Pi
// rev 1.0
// ---------------------------------------------------------------------------
module tipi_spi_pi_bus
    import tipi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RD_RESET    = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [0:7] td,
    input  logic [0:7] tc,
    output logic [0:7] rd,
    output logic [0:7] rc,
    output logic       rd_wr,
    output logic       rc_wr,
    output logic       busy
);

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_h, cs_n_h;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    // Chains and history reset low: a cs_n held low across reset can then
    // never masquerade as a falling edge, so only a fresh select starts a frame.
    tipi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(spi_sclk), .q(sclk_s)
    );
    tipi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs_n (
        .clk(clk), .reset(reset), .d(spi_cs_n), .q(cs_n_s)
    );
    tipi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(spi_mosi), .q(mosi_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_h <= 1'b0;
            cs_n_h <= 1'b0;
        end else begin
            sclk_h <= sclk_s;
            cs_n_h <= cs_n_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_h;
    assign sclk_fall = ~sclk_s & sclk_h;
    assign cs_fall   = ~cs_n_s & cs_n_h;
    assign cs_rise   = cs_n_s & ~cs_n_h;

    state_t     state, state_next;
    logic [4:0] bit_cnt;
    logic [7:0] rx_sh, tx_sh, cmd, commit_data;
    logic [7:0] rx_next;
    logic       miso_q, commit_rd, commit_rc;
    logic       byte_done, frame_done;

    assign rx_next = {rx_sh[6:0], mosi_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_done  = 1'b0;
        frame_done = 1'b0;
        if (cs_fall) begin
            state_next = ST_CMD;
        end else if (cs_rise) begin
            state_next = ST_IDLE;
        end else if (sclk_rise) begin
            case (state)
                ST_CMD: begin
                    if (bit_cnt == 5'(CMD_BITS - 1)) begin
                        state_next = ST_DATA;
                        byte_done  = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                        state_next = ST_DONE;
                        frame_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            cmd         <= '0;
            miso_q      <= 1'b0;
            commit_rd   <= 1'b0;
            commit_rc   <= 1'b0;
            commit_data <= '0;
            rd          <= RD_RESET;
            rc          <= RD_RESET;
            rd_wr       <= 1'b0;
            rc_wr       <= 1'b0;
        end else begin
            rd_wr     <= 1'b0;
            rc_wr     <= 1'b0;
            commit_rd <= 1'b0;
            commit_rc <= 1'b0;
            if (commit_rd) begin
                rd    <= commit_data;
                rd_wr <= 1'b1;
            end
            if (commit_rc) begin
                rc    <= commit_data;
                rc_wr <= 1'b1;
            end

            if (cs_fall) begin
                bit_cnt <= '0;
                rx_sh   <= '0;
                tx_sh   <= '0;
                miso_q  <= 1'b0;
            end else if (state != ST_IDLE) begin
                if (sclk_rise) begin
                    if (bit_cnt != 5'(FRAME_BITS)) begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                    if (state != ST_DONE) begin
                        rx_sh <= rx_next;
                    end
                    if (byte_done) begin
                        cmd <= rx_next;
                        case (rx_next)
                            CMD_RD_TD: tx_sh <= td;
                            CMD_RD_TC: tx_sh <= tc;
                            default:   tx_sh <= '0;
                        endcase
                    end
                    if (frame_done) begin
                        commit_data <= rx_next;
                        commit_rd   <= (cmd == CMD_WR_RD);
                        commit_rc   <= (cmd == CMD_WR_RC);
                    end
                end
                // Only the data byte of a read carries payload; everything else shifts zeros.
                if (sclk_fall) begin
                    if (state == ST_DATA) begin
                        miso_q <= tx_sh[7];
                        tx_sh  <= {tx_sh[6:0], 1'b0};
                    end else begin
                        miso_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign busy     = (state != ST_IDLE);
    assign spi_miso = (state != ST_IDLE) ? miso_q : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_tipi_spi_pi_bus.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tipi_spi_pi_bus: scoreboard bench driving Pi-side SPI frames at f_clk/8
// rev 1.0
// ---------------------------------------------------------------------------
module tb_tipi_spi_pi_bus;

    localparam logic [7:0] RD_RESET = 8'hC3;
    localparam int         HALF     = 40;
    localparam int         N_RANDOM = 400;

    localparam logic [2:0] K_CAP_CMD  = 3'd0;
    localparam logic [2:0] K_CAP_DAT  = 3'd1;
    localparam logic [2:0] K_CAP_TAIL = 3'd2;
    localparam logic [2:0] K_RD       = 3'd3;
    localparam logic [2:0] K_RC       = 3'd4;
    localparam logic [2:0] K_NRD      = 3'd5;
    localparam logic [2:0] K_NRC      = 3'd6;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] val;
    } exp_t;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    wire        spi_miso;
    logic [0:7] td = 8'h00;
    logic [0:7] tc = 8'h00;
    logic [0:7] rd, rc;
    logic       rd_wr, rc_wr, busy;

    int   total = 0;
    int   bad   = 0;
    int   n_rd_wr = 0;
    int   n_rc_wr = 0;
    exp_t sb[$];
    logic [7:0] model_rd = RD_RESET;
    logic [7:0] model_rc = RD_RESET;

    always #5 clk = ~clk;

    tipi_spi_pi_bus #(
        .SYNC_STAGES(2),
        .RD_RESET(RD_RESET)
    ) dut (
        .clk(clk),
        .reset(reset),
        .spi_sclk(spi_sclk),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .td(td),
        .tc(tc),
        .rd(rd),
        .rc(rc),
        .rd_wr(rd_wr),
        .rc_wr(rc_wr),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp_v, $time);
        end
    endtask

    // Strobe counting plus register stability outside strobe cycles.
    logic [7:0] prev_rd = RD_RESET;
    logic [7:0] prev_rc = RD_RESET;
    logic       prev_reset = 1'b1;
    always @(negedge clk) begin
        if (rd_wr) n_rd_wr++;
        if (rc_wr) n_rc_wr++;
        if (!reset && !prev_reset) begin
            if (!rd_wr && rd !== prev_rd) check("rd_stable", rd, prev_rd);
            if (!rc_wr && rc !== prev_rc) check("rc_stable", rc, prev_rc);
        end
        prev_rd    = rd;
        prev_rc    = rc;
        prev_reset = reset;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [2:0] kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] cap_byte(input logic [23:0] cap, input int n, input int k);
        logic [23:0] t;
        t = cap >> (n - 8 * (k + 1));
        return t[7:0];
    endfunction

    task automatic spi_xfer(input logic [23:0] bits, input int n, input bit quick,
                            input int tc_bit, input logic [7:0] tc_new,
                            output logic [23:0] cap);
        cap = '0;
        if (quick) #10;
        else begin
            @(posedge clk);
            #(1 + $urandom_range(8));
        end
        spi_cs_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = bits[n-1-i];
            if (i == tc_bit) tc = tc_new;
            #HALF;
            spi_sclk = 1'b1;
            cap[n-1-i] = spi_miso;
            #HALF;
            spi_sclk = 1'b0;
        end
        #HALF;
        spi_cs_n = 1'b1;
        spi_mosi = 1'($urandom_range(1));
    endtask

    task automatic expect_frame(input logic [7:0] cmd, input logic [7:0] dat, input int n);
        logic [7:0] snap;
        logic       wr_rd, wr_rc;
        wr_rd = 1'b0;
        wr_rc = 1'b0;
        if (n >= 16) begin
            case (cmd)
                8'h00:   snap = td;
                8'h01:   snap = tc;
                default: snap = 8'h00;
            endcase
            push(K_CAP_CMD, 8'h00);
            push(K_CAP_DAT, snap);
            if (n > 16) push(K_CAP_TAIL, 8'h00);
            if (cmd == 8'h02) begin model_rd = dat; wr_rd = 1'b1; end
            if (cmd == 8'h03) begin model_rc = dat; wr_rc = 1'b1; end
        end
        push(K_RD, model_rd);
        push(K_RC, model_rc);
        push(K_NRD, {7'd0, wr_rd});
        push(K_NRC, {7'd0, wr_rc});
    endtask

    task automatic drain(input logic [23:0] cap, input int n, input int r0, input int c0);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_CAP_CMD:  check("miso_cmd_byte", cap_byte(cap, n, 0), e.val);
                K_CAP_DAT:  check("miso_data_byte", cap_byte(cap, n, 1), e.val);
                K_CAP_TAIL: check("miso_overlength", cap_byte(cap, n, 2), e.val);
                K_RD:       check("rd_value", rd, e.val);
                K_RC:       check("rc_value", rc, e.val);
                K_NRD:      check("rd_wr_pulses", n_rd_wr - r0, e.val);
                default:    check("rc_wr_pulses", n_rc_wr - c0, e.val);
            endcase
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] dat, input int n,
                             input int tc_bit, input logic [7:0] tc_new, input logic [7:0] tail);
        logic [23:0] bits, cap;
        int r0, c0;
        bits = {8'h00, cmd, dat};
        if (n > 16) bits = {cmd, dat, tail};
        else bits = bits >> (16 - n);
        expect_frame(cmd, dat, n);
        r0 = n_rd_wr;
        c0 = n_rc_wr;
        spi_xfer(bits, n, 1'b0, tc_bit, tc_new, cap);
        repeat (8) @(negedge clk);
        #1;
        drain(cap, n, r0, c0);
    endtask

    initial begin
        logic [15:0] bits16;
        logic [23:0] cap;
        logic [7:0]  cmd, dat;
        int r0, c0, n;

        repeat (4) @(negedge clk);
        #1;
        check("reset_rd", rd, RD_RESET);
        check("reset_rc", rc, RD_RESET);
        check("reset_rd_wr", rd_wr, 0);
        check("reset_rc_wr", rc_wr, 0);
        check("reset_busy", busy, 0);
        check("reset_miso_hiz", (spi_miso === 1'bz) ? 1 : 0, 1);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        run_frame(8'h02, 8'hA5, 16, -1, 8'h00, 8'h00);
        tc = 8'h3C;
        run_frame(8'h01, 8'h00, 16, 11, 8'hFF, 8'h00);
        td = 8'h96;
        run_frame(8'h00, 8'h00, 16, -1, 8'h00, 8'h00);
        run_frame(8'h03, 8'hE7, 13, -1, 8'h00, 8'h00);
        run_frame(8'h03, 8'h5A, 16, -1, 8'h00, 8'h00);
        run_frame(8'h7E, 8'h11, 16, -1, 8'h00, 8'h00);
        run_frame(8'h02, 8'h81, 24, -1, 8'h00, 8'hFF);

        // Back-to-back frames with cs_n high for a single clk.
        push(K_RD, 8'h11);
        push(K_RC, 8'h22);
        push(K_NRD, 8'd1);
        push(K_NRC, 8'd1);
        model_rd = 8'h11;
        model_rc = 8'h22;
        r0 = n_rd_wr;
        c0 = n_rc_wr;
        spi_xfer({8'h00, 8'h02, 8'h11}, 16, 1'b0, -1, 8'h00, cap);
        spi_xfer({8'h00, 8'h03, 8'h22}, 16, 1'b1, -1, 8'h00, cap);
        repeat (8) @(negedge clk);
        #1;
        drain(cap, 16, r0, c0);

        // Reset in the middle of a write frame.
        bits16 = {8'h02, 8'h3C};
        @(posedge clk);
        #3;
        spi_cs_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            spi_mosi = bits16[15-i];
            #HALF; spi_sclk = 1'b1;
            #HALF; spi_sclk = 1'b0;
        end
        #1;
        check("busy_in_frame", busy, 1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("midreset_rd", rd, RD_RESET);
        check("midreset_rc", rc, RD_RESET);
        check("midreset_busy", busy, 0);
        check("midreset_miso_hiz", (spi_miso === 1'bz) ? 1 : 0, 1);
        model_rd = RD_RESET;
        model_rc = RD_RESET;
        r0 = n_rd_wr;
        reset = 1'b0;
        for (int i = 10; i < 16; i++) begin
            spi_mosi = bits16[15-i];
            #HALF; spi_sclk = 1'b1;
            #HALF; spi_sclk = 1'b0;
        end
        #HALF;
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("postreset_rd", rd, RD_RESET);
        check("postreset_rd_wr", n_rd_wr - r0, 0);
        run_frame(8'h02, 8'h42, 16, -1, 8'h00, 8'h00);

        for (int k = 0; k < N_RANDOM; k++) begin
            case ($urandom_range(4))
                0: cmd = 8'h00;
                1: cmd = 8'h01;
                2: cmd = 8'h02;
                3: cmd = 8'h03;
                default: cmd = 8'(4 + $urandom_range(251));
            endcase
            dat = 8'($urandom);
            td  = 8'($urandom);
            tc  = 8'($urandom);
            n   = ($urandom_range(7) == 0) ? 24 : 16;
            run_frame(cmd, dat, n, -1, 8'h00, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
